waves_nios_ocimem_engine: RTL and testbench

- On-chip debug memory engine that sits directly downstream of the JTAG debug-module wrapper.
- Consumes jdo[37:0] and the take_action_ocimem_a / take_action_ocimem_b / take_no_action_ocimem_a strobes.
- Performs word reads and writes into a private debug RAM, with auto-incrementing address.
- Produces MonDReg, monitor_ready and monitor_error, which feed back into the wrapper. The CPU reaches the same RAM through an Avalon-MM slave port; JTAG has priority.

---
 rtl/waves_nios_ocimem_pkg.sv | 27 ++
 rtl/waves_nios_ocimem_ram.sv | 25 ++
 rtl/waves_nios_ocimem_engine.sv | 157 +++++++++++++++
 tb/tb_waves_nios_ocimem_engine.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/waves_nios_ocimem_pkg.sv
// Shared types and jdo field positions for the OCI debug memory engine.
package waves_nios_ocimem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    JWR,
    JRD,
    JCAP,
    CWR,
    CRD,
    CCAP
  } state_e;

  typedef enum logic [1:0] {
    NONE,
    RD,
    WR
  } pend_e;

  localparam int unsigned JDO_W         = 38;
  localparam int unsigned JDO_ADDR_LSB  = 26;
  localparam int unsigned JDO_CLRERR    = 25;
  localparam int unsigned JDO_RDGO      = 17;
  localparam int unsigned JDO_RDCONT    = 35;
  localparam int unsigned JDO_WDATA_LSB = 3;

endpackage

// File: rtl/waves_nios_ocimem_ram.sv
// Single-port synchronous debug RAM, registered read, no reset.
module waves_nios_ocimem_ram #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/waves_nios_ocimem_engine.sv
// OCI debug memory engine: JTAG word access with auto-increment plus an Avalon-MM CPU port.
// Optional macro WAVES_OCIMEM_WRPROT_EN drops CPU writes to the top quarter of the RAM.
module waves_nios_ocimem_engine
  import waves_nios_ocimem_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [DATA_W-1:0] av_writedata,
  output logic [DATA_W-1:0] av_readdata,
  output logic              av_waitrequest
);

  state_e            state_q;
  pend_e             pend_q;
  logic [ADDR_W-1:0] mon_areg_q;
  logic [DATA_W-1:0] mon_dreg_q;
  logic [DATA_W-1:0] pend_data_q;
  logic [DATA_W-1:0] jwr_data_q;
  logic [DATA_W-1:0] readdata_q;
  logic              ready_q;
  logic              error_q;

  logic              q_rd_c;
  logic              q_wr_c;
  logic              slot_busy_c;
  logic              wr_prot_c;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              unused_jdo;

  assign unused_jdo = ^{jdo[JDO_W-1:JDO_RDCONT+1], jdo[JDO_WDATA_LSB-1:0]};

  assign q_wr_c = take_action_ocimem_b;
  assign q_rd_c = (take_action_ocimem_a && jdo[JDO_RDGO]) ||
                  (take_no_action_ocimem_a && jdo[JDO_RDCONT]);
  // The slot is only free when IDLE is consuming it this very cycle.
  assign slot_busy_c = (pend_q != NONE) && (state_q != IDLE);

`ifdef WAVES_OCIMEM_WRPROT_EN
  assign wr_prot_c = (av_address[ADDR_W-1 -: 2] == 2'b11);
`else
  assign wr_prot_c = 1'b0;
`endif

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = mon_areg_q;
    ram_wdata = jwr_data_q;
    case (state_q)
      JWR: ram_we = reset_n;
      CWR: begin
        ram_addr  = av_address;
        ram_wdata = av_writedata;
        ram_we    = reset_n && !wr_prot_c;
      end
      CRD:     ram_addr = av_address;
      default: ;
    endcase
  end

  waves_nios_ocimem_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pend_q      <= NONE;
      mon_areg_q  <= '0;
      mon_dreg_q  <= '0;
      pend_data_q <= '0;
      jwr_data_q  <= '0;
      readdata_q  <= '0;
      ready_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pend_q == RD) begin
            state_q <= JRD;
          end else if (pend_q == WR) begin
            state_q    <= JWR;
            jwr_data_q <= pend_data_q;
          end else if (av_read) begin
            state_q <= CRD;
          end else if (av_write) begin
            state_q <= CWR;
          end
          pend_q <= NONE;
        end
        JWR: begin
          mon_areg_q <= mon_areg_q + ADDR_W'(1);
          state_q    <= IDLE;
        end
        JRD: state_q <= JCAP;
        JCAP: begin
          mon_dreg_q <= ram_rdata;
          ready_q    <= 1'b1;
          mon_areg_q <= mon_areg_q + ADDR_W'(1);
          state_q    <= IDLE;
        end
        CWR: state_q <= IDLE;
        CRD: state_q <= CCAP;
        CCAP: begin
          readdata_q <= ram_rdata;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // Strobes override FSM updates: a fresh command is newer than any in-flight result.
      if (take_action_ocimem_a) begin
        mon_areg_q <= jdo[JDO_ADDR_LSB +: ADDR_W];
        if (jdo[JDO_CLRERR]) error_q <= 1'b0;
      end
      if (q_wr_c) begin
        mon_dreg_q  <= jdo[JDO_WDATA_LSB +: DATA_W];
        pend_data_q <= jdo[JDO_WDATA_LSB +: DATA_W];
      end
      if (q_rd_c || q_wr_c) begin
        pend_q  <= q_wr_c ? WR : RD;
        ready_q <= 1'b0;
        if (slot_busy_c) error_q <= 1'b1;
      end
    end
  end

  assign MonDReg        = mon_dreg_q;
  assign monitor_ready  = ready_q;
  assign monitor_error  = error_q;
  assign av_readdata    = (state_q == CCAP) ? ram_rdata : readdata_q;
  assign av_waitrequest = !reset_n ||
                          ((state_q != CWR) && (state_q != CCAP) && (av_read || av_write));

endmodule

// File: tb/tb_waves_nios_ocimem_engine.sv
// Randomized bench for the OCI debug memory engine against an array-based memory model.
module tb_waves_nios_ocimem_engine;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [37:0] jdo = '0;
  logic        ta_a = 1'b0, ta_b = 1'b0, tna_a = 1'b0;
  logic [31:0] mon_dreg;
  logic        mon_ready, mon_err;
  logic [7:0]  av_address = '0;
  logic        av_read = 1'b0, av_write = 1'b0;
  logic [31:0] av_writedata = '0;
  logic [31:0] av_readdata;
  logic        av_waitrequest;

  always #5 clk = ~clk;

  waves_nios_ocimem_engine dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (ta_a),
    .take_action_ocimem_b    (ta_b),
    .take_no_action_ocimem_a (tna_a),
    .MonDReg                 (mon_dreg),
    .monitor_ready           (mon_ready),
    .monitor_error           (mon_err),
    .av_address              (av_address),
    .av_read                 (av_read),
    .av_write                (av_write),
    .av_writedata            (av_writedata),
    .av_readdata             (av_readdata),
    .av_waitrequest          (av_waitrequest)
  );

  // Reference model: memory array plus the monitor registers.
  logic [31:0] m_mem [256];
  logic [7:0]  m_areg;
  logic [31:0] m_dreg;
  logic        m_ready, m_err;
  bit          prot_en;
  int          n_checks = 0;
  int          n_errs = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] rnd_jdo();
    return {6'($urandom), 32'($urandom)};
  endfunction

  task automatic check_state(input string tag);
    check({tag, "_dreg"}, mon_dreg, m_dreg);
    check({tag, "_ready"}, 32'(mon_ready), 32'(m_ready));
    check({tag, "_err"}, 32'(mon_err), 32'(m_err));
  endtask

  // Waits for the read result; latency counted in clock edges after the strobe edge.
  task automatic jtag_rd_finish(input string tag);
    int n = 0;
    m_ready = 1'b0;
    while (n < 20) begin
      @(negedge clk);
      if (mon_ready) break;
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'd3);
    m_dreg  = m_mem[m_areg];
    m_areg  = m_areg + 8'd1;
    m_ready = 1'b1;
    check({tag, "_data"}, mon_dreg, m_dreg);
    tick();
  endtask

  task automatic jtag_addr(input logic [7:0] a, input bit rdgo, input bit clr);
    logic [37:0] j = rnd_jdo();
    j[33:26] = a;
    j[25]    = clr;
    j[17]    = rdgo;
    jdo = j; ta_a = 1'b1;
    tick();
    ta_a = 1'b0; jdo = rnd_jdo();
    m_areg = a;
    if (clr) m_err = 1'b0;
    if (rdgo) jtag_rd_finish("addr_rd");
  endtask

  task automatic jtag_rdcont();
    logic [37:0] j = rnd_jdo();
    j[35] = 1'b1;
    jdo = j; tna_a = 1'b1;
    tick();
    tna_a = 1'b0; jdo = rnd_jdo();
    jtag_rd_finish("cont_rd");
  endtask

  task automatic jtag_wr(input logic [31:0] d);
    logic [37:0] j = rnd_jdo();
    j[34:3] = d;
    jdo = j; ta_b = 1'b1;
    tick();
    ta_b = 1'b0; jdo = rnd_jdo();
    m_dreg = d; m_ready = 1'b0;
    repeat (3) tick();
    m_mem[m_areg] = d;
    m_areg = m_areg + 8'd1;
  endtask

  task automatic cpu_op(input bit wr, input bit rd_too, input logic [7:0] a, input logic [31:0] d,
                        output logic [31:0] rdata, output int waits);
    av_address = a; av_writedata = d; av_write = wr; av_read = !wr || rd_too;
    waits = 0; rdata = '0;
    while (waits < 20) begin
      @(negedge clk);
      if (!av_waitrequest) begin
        rdata = av_readdata;
        break;
      end
      waits++;
    end
    tick();
    av_read = 1'b0; av_write = 1'b0;
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] rd;
    int w;
    cpu_op(1'b1, 1'b0, a, d, rd, w);
    check("cpu_wr_wait", 32'(w), 32'd1);
    if (!(prot_en && a[7:6] == 2'b11)) m_mem[a] = d;
  endtask

  task automatic cpu_read(input logic [7:0] a);
    logic [31:0] rd;
    int w;
    cpu_op(1'b0, 1'b0, a, 32'h0, rd, w);
    check("cpu_rd_wait", 32'(w), 32'd2);
    check("cpu_rd_data", rd, m_mem[a]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  a, wa;
    int          w;
`ifdef WAVES_OCIMEM_WRPROT_EN
    prot_en = 1'b1;
`else
    prot_en = 1'b0;
`endif
    m_areg = '0; m_dreg = '0; m_ready = 1'b0; m_err = 1'b0;

    repeat (3) tick();
    @(negedge clk);
    check("rst_wait", 32'(av_waitrequest), 32'd1);
    check("rst_rdata", av_readdata, 32'h0);
    check_state("rst");
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_wait_rel", 32'(av_waitrequest), 32'd0);
    tick();

    // Fill the whole RAM through JTAG auto-increment; address wraps back to 0.
    jtag_addr(8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 256; i++) jtag_wr($urandom);
    check_state("init");

    jtag_addr(8'h10, 1'b0, 1'b0);
    jtag_wr(32'hDEADBEEF);
    jtag_addr(8'h10, 1'b1, 1'b0);
    check("rb_data", mon_dreg, 32'hDEADBEEF);
    check_state("rb");
    jtag_rdcont();

    jtag_addr(8'hFF, 1'b0, 1'b0);
    jtag_wr(32'h1);
    jtag_wr(32'h2);
    cpu_read(8'hFF);
    cpu_read(8'h00);
    check("wrap_data0", m_mem[0], 32'h2);

    // Overrun: two read-continue strobes while the CPU read is in CRD/CCAP.
    av_address = 8'h40; av_read = 1'b1;
    tick();
    jdo = rnd_jdo(); jdo[35] = 1'b1; tna_a = 1'b1;
    tick();
    jdo = rnd_jdo(); jdo[35] = 1'b1;
    @(negedge clk);
    check("ovr_cpu_wait", 32'(av_waitrequest), 32'd0);
    check("ovr_cpu_data", av_readdata, m_mem[8'h40]);
    tick();
    tna_a = 1'b0; av_read = 1'b0;
    m_err = 1'b1;
    jtag_rd_finish("ovr");
    check_state("ovr");
    jtag_rdcont();
    check_state("ovr_next");
    jtag_addr(8'h50, 1'b0, 1'b1);
    check_state("clr_err");

    // Pending JTAG write beats a CPU write presented in the same IDLE cycle.
    wa = m_areg;
    jdo = rnd_jdo(); jdo[34:3] = 32'hCAFE0001; ta_b = 1'b1;
    tick();
    ta_b = 1'b0;
    m_dreg = 32'hCAFE0001; m_ready = 1'b0;
    m_mem[m_areg] = 32'hCAFE0001; m_areg = m_areg + 8'd1;
    cpu_op(1'b1, 1'b0, 8'h20, 32'h5, rd, w);
    m_mem[8'h20] = 32'h5;
    check("prio_wait", 32'(w), 32'd3);
    cpu_read(8'h20);
    jtag_addr(wa, 1'b1, 1'b0);

    // Read and write together: only the read happens.
    cpu_op(1'b1, 1'b1, 8'h30, 32'hBAD0BAD0, rd, w);
    check("rw_data", rd, m_mem[8'h30]);
    cpu_read(8'h30);

    cpu_write(8'hC0, 32'h1234);
    jtag_addr(8'hC0, 1'b1, 1'b0);
    check_state("prot");

    // Reset while the JTAG write is in JWR must suppress the RAM write.
    jtag_addr(8'h33, 1'b0, 1'b0);
    jdo = rnd_jdo(); jdo[34:3] = 32'h0BADF00D; ta_b = 1'b1;
    tick();
    ta_b = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    m_areg = '0; m_dreg = '0; m_ready = 1'b0; m_err = 1'b0;
    check_state("rst_mid");
    jtag_addr(8'h33, 1'b1, 1'b0);

    for (int i = 0; i < 150; i++) begin
      a = 8'($urandom);
      case ($urandom_range(0, 5))
        0: jtag_addr(a, 1'($urandom), 1'($urandom));
        1: jtag_wr($urandom);
        2: jtag_rdcont();
        3: cpu_write(a, $urandom);
        4: cpu_read(a);
        default: begin
          cpu_op(1'b1, 1'b1, a, $urandom, rd, w);
          check("rnd_rw", rd, m_mem[a]);
        end
      endcase
      check_state("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
